dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache placed between the CPU data port and data memory. On the CPU side it is the responder, using the same READ/WRITE/ADDRESS/WRITEDATA/READDATA/BUSYWAIT handshake the CPU already drives. On the memory side it is the initiator, issuing 4-byte block reads and writes to a block-addressed main memory. Hits complete without stalling; misses stall the CPU through BUSYWAIT until the line is refilled.

---
 rtl/dcache_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller sitting between
// the CPU data port and a block-addressed main memory.
`timescale 1ns/1ps
module dcache_ctrl #(
    parameter int INDEX_BITS  = 3,
    parameter int BLOCK_BYTES = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    localparam int OFFSET_BITS = $clog2(BLOCK_BYTES);
    localparam int TAG_BITS    = 6 - INDEX_BITS;
    localparam int LINES       = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        MEM_FETCH  = 2'd2,
        REFILL     = 2'd3
    } state_t;

    state_t state_r, next_state_s;

    logic [LINES-1:0]    valid_r;
    logic [LINES-1:0]    dirty_r;
    logic [TAG_BITS-1:0] tag_r  [LINES];
    logic [31:0]         data_r [LINES];
    logic [7:0]          rdata_hold_r;

    logic [TAG_BITS-1:0]   tag_s;
    logic [INDEX_BITS-1:0] index_s;
    logic [1:0]            offset_s;
    logic                  req_s;
    logic                  hit_s;
    logic                  idle_hit_s;
    logic [31:0]           line_data_s;
    logic [7:0]            sel_byte_s;
    logic                  mem_read_s;
    logic                  mem_write_s;
    logic [5:0]            mem_addr_s;

    function automatic logic [7:0] byte_sel(input logic [31:0] blk, input logic [1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = blk[7:0];
            2'd1:    b = blk[15:8];
            2'd2:    b = blk[23:16];
            2'd3:    b = blk[31:24];
            default: b = blk[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] blk, input logic [1:0] off,
                                               input logic [7:0] b);
        logic [31:0] r;
        r = blk;
        case (off)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

    assign tag_s       = ADDRESS[7 -: TAG_BITS];
    assign index_s     = ADDRESS[OFFSET_BITS +: INDEX_BITS];
    assign offset_s    = ADDRESS[OFFSET_BITS-1:0];
    assign req_s       = READ | WRITE;
    assign line_data_s = data_r[index_s];
    assign hit_s       = valid_r[index_s] & (tag_r[index_s] == tag_s);
    assign idle_hit_s  = (state_r == IDLE) & hit_s;
    assign sel_byte_s  = byte_sel(line_data_s, offset_s);

    // Reset gates the stall so the CPU is released the moment RESET_N drops.
    assign BUSYWAIT      = RESET_N & req_s & ~idle_hit_s;
    assign READDATA      = hit_s ? sel_byte_s : rdata_hold_r;
    assign MEM_READ      = mem_read_s;
    assign MEM_WRITE     = mem_write_s;
    assign MEM_ADDRESS   = mem_addr_s;
    assign MEM_WRITEDATA = line_data_s;

    // Next-state and memory strobe decode.
    always_comb begin
        next_state_s = state_r;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        mem_addr_s   = {tag_s, index_s};
        case (state_r)
            IDLE: begin
                if (req_s && !hit_s) begin
                    if (valid_r[index_s] && dirty_r[index_s]) begin
                        next_state_s = WRITE_BACK;
                    end else begin
                        next_state_s = MEM_FETCH;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WRITE_BACK: begin
                mem_write_s = 1'b1;
                mem_addr_s  = {tag_r[index_s], index_s};
                if (!MEM_BUSYWAIT) begin
                    next_state_s = MEM_FETCH;
                end else begin
                    next_state_s = WRITE_BACK;
                end
            end
            MEM_FETCH: begin
                mem_read_s = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    next_state_s = REFILL;
                end else begin
                    next_state_s = MEM_FETCH;
                end
            end
            REFILL: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Line storage: refill from memory, or byte update on a write hit.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_r <= '0;
            dirty_r <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_r[i]  <= '0;
                data_r[i] <= 32'h0000_0000;
            end
        end else if (state_r == REFILL) begin
            data_r[index_s]  <= MEM_READDATA;
            tag_r[index_s]   <= tag_s;
            valid_r[index_s] <= 1'b1;
            dirty_r[index_s] <= 1'b0;
        end else if (idle_hit_s && WRITE) begin
            data_r[index_s]  <= byte_merge(line_data_s, offset_s, WRITEDATA);
            dirty_r[index_s] <= 1'b1;
        end
    end

    // Last hit byte, presented on READDATA while the access is not a hit.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rdata_hold_r <= 8'h00;
        end else if (hit_s) begin
            rdata_hold_r <= sel_byte_s;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random accesses
// checked against a line-level cache model and a latency-configurable memory.
`timescale 1ns/1ps
module tb_dcache_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = 8'h00;
    logic [7:0]  WRITEDATA = 8'h00;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA = 32'h0;
    logic        MEM_BUSYWAIT = 1'b0;

    always #5 CLK = ~CLK;

    dcache_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    int nvec = 0;
    int nfail = 0;

    // Reference cache model and expected memory image.
    bit          mvalid [8];
    bit          mdirty [8];
    logic [2:0]  mtag   [8];
    logic [31:0] mdata  [8];
    logic [31:0] ref_mem   [64];
    logic [31:0] mem_store [64];

    // Memory responder state and transaction log.
    int          mem_lat = 1;
    bit          mem_active = 1'b0;
    int          mem_cnt = 0;
    bit          cur_wr;
    logic [5:0]  cur_addr;
    logic [31:0] cur_data;
    bit          log_wr   [$];
    logic [5:0]  log_addr [$];
    logic [31:0] log_data [$];

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (!RESET_N) begin
                mem_active   = 1'b0;
                MEM_BUSYWAIT = 1'b0;
            end else begin
                if (MEM_READ || MEM_WRITE) begin
                    nvec++;
                    if (MEM_READ && MEM_WRITE) begin
                        nfail++;
                        $display("FAIL strobe_exclusive got MEM_READ=%b MEM_WRITE=%b required not both", MEM_READ, MEM_WRITE);
                    end
                end
                if (mem_active && mem_cnt == 0) begin
                    if (cur_wr) mem_store[cur_addr] = cur_data;
                    mem_active = 1'b0;
                end else if (mem_active) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        MEM_BUSYWAIT = 1'b0;
                        if (!cur_wr) MEM_READDATA = mem_store[cur_addr];
                    end
                end
                if (!mem_active && (MEM_READ || MEM_WRITE)) begin
                    cur_wr   = MEM_WRITE;
                    cur_addr = MEM_ADDRESS;
                    cur_data = MEM_WRITEDATA;
                    log_wr.push_back(MEM_WRITE);
                    log_addr.push_back(MEM_ADDRESS);
                    log_data.push_back(MEM_WRITEDATA);
                    MEM_BUSYWAIT = 1'b1;
                    mem_cnt      = mem_lat;
                    mem_active   = 1'b1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] get_byte(input logic [31:0] b, input logic [1:0] o);
        return b[o*8 +: 8];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
    endtask

    task automatic do_access(input bit wr, input bit both, input logic [7:0] addr, input logic [7:0] wd);
        logic [2:0] idx;
        logic [2:0] tg;
        logic [1:0] off;
        bit         exp_hit;
        bit         exp_wb;
        int         cyc;
        idx = addr[4:2];
        tg  = addr[7:5];
        off = addr[1:0];
        @(negedge CLK);
        READ      = !wr || both;
        WRITE     = wr;
        ADDRESS   = addr;
        WRITEDATA = wd;
        log_wr.delete();
        log_addr.delete();
        log_data.delete();
        #1;
        exp_hit = mvalid[idx] && (mtag[idx] == tg);
        nvec++;
        if (BUSYWAIT !== !exp_hit) begin
            nfail++;
            $display("FAIL busywait_onset addr=%h got=%b required=%b", addr, BUSYWAIT, !exp_hit);
        end
        if (exp_hit) begin
            nvec++;
            if ({MEM_READ, MEM_WRITE} !== 2'b00) begin
                nfail++;
                $display("FAIL hit_no_strobe addr=%h got rd=%b wr=%b required 0 0", addr, MEM_READ, MEM_WRITE);
            end
        end else begin
            exp_wb = mvalid[idx] && mdirty[idx];
            cyc = 0;
            while (BUSYWAIT !== 1'b0 && cyc < 200) begin
                @(negedge CLK);
                #1;
                cyc++;
            end
            nvec++;
            if (cyc >= 200) begin
                nfail++;
                $display("FAIL miss_timeout addr=%h BUSYWAIT=%b required 0 within 200 cycles", addr, BUSYWAIT);
            end
            nvec++;
            if (log_wr.size() != (exp_wb ? 2 : 1)) begin
                nfail++;
                $display("FAIL txn_count addr=%h got=%0d required=%0d", addr, log_wr.size(), exp_wb ? 2 : 1);
            end else begin
                if (exp_wb) begin
                    nvec++;
                    if (log_wr[0] !== 1'b1 || log_addr[0] !== {mtag[idx], idx} || log_data[0] !== mdata[idx]) begin
                        nfail++;
                        $display("FAIL writeback got wr=%b addr=%h data=%h required wr=1 addr=%h data=%h",
                                 log_wr[0], log_addr[0], log_data[0], {mtag[idx], idx}, mdata[idx]);
                    end
                end
                nvec++;
                if (log_wr[$] !== 1'b0 || log_addr[$] !== {tg, idx}) begin
                    nfail++;
                    $display("FAIL fetch got wr=%b addr=%h required wr=0 addr=%h", log_wr[$], log_addr[$], {tg, idx});
                end
            end
            if (exp_wb) ref_mem[{mtag[idx], idx}] = mdata[idx];
            mvalid[idx] = 1'b1;
            mdirty[idx] = 1'b0;
            mtag[idx]   = tg;
            mdata[idx]  = ref_mem[{tg, idx}];
        end
        if (!wr) begin
            nvec++;
            if (READDATA !== get_byte(mdata[idx], off)) begin
                nfail++;
                $display("FAIL readdata addr=%h got=%h required=%h", addr, READDATA, get_byte(mdata[idx], off));
            end
        end else begin
            mdata[idx][off*8 +: 8] = wd;
            mdirty[idx] = 1'b1;
        end
        @(posedge CLK);
        #1;
        READ  = 1'b0;
        WRITE = 1'b0;
    endtask

    task automatic test_reset();
        #($urandom_range(1, 9));
        RESET_N = 1'b0;
        #1;
        nvec++;
        if ({BUSYWAIT, MEM_READ, MEM_WRITE} !== 3'b000) begin
            nfail++;
            $display("FAIL reset_outputs got bw=%b rd=%b wr=%b required 0 0 0", BUSYWAIT, MEM_READ, MEM_WRITE);
        end
        model_clear();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_read_miss();
        mem_lat = 2;
        do_access(1'b0, 1'b0, 8'h05, 8'h00);
    endtask

    task automatic test_read_hit();
        do_access(1'b0, 1'b0, 8'h06, 8'h00);
    endtask

    task automatic test_write_hit();
        do_access(1'b1, 1'b0, 8'h04, 8'hAB);
        do_access(1'b0, 1'b0, 8'h04, 8'h00);
    endtask

    task automatic test_dirty_evict();
        mem_lat = 3;
        do_access(1'b0, 1'b0, 8'h24, 8'h00);
    endtask

    task automatic test_write_miss();
        mem_lat = 1;
        do_access(1'b1, 1'b0, 8'h10, 8'h5A);
        do_access(1'b0, 1'b0, 8'h10, 8'h00);
    endtask

    task automatic test_reset_mid_miss();
        int cyc;
        mem_lat = 5;
        @(negedge CLK);
        READ    = 1'b1;
        ADDRESS = 8'h48;
        cyc = 0;
        #1;
        while (!(MEM_READ === 1'b1 && MEM_BUSYWAIT === 1'b1) && cyc < 20) begin
            @(negedge CLK);
            #1;
            cyc++;
        end
        nvec++;
        if (cyc >= 20) begin
            nfail++;
            $display("FAIL mid_miss_start MEM_READ=%b MEM_BUSYWAIT=%b required 1 1", MEM_READ, MEM_BUSYWAIT);
        end
        #2;
        RESET_N = 1'b0;
        #1;
        nvec++;
        if ({BUSYWAIT, MEM_READ, MEM_WRITE} !== 3'b000) begin
            nfail++;
            $display("FAIL mid_miss_reset got bw=%b rd=%b wr=%b required 0 0 0", BUSYWAIT, MEM_READ, MEM_WRITE);
        end
        READ = 1'b0;
        model_clear();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        mem_lat = 2;
        do_access(1'b0, 1'b0, 8'h48, 8'h00);
    endtask

    task automatic test_random();
        bit         wr;
        bit         both;
        logic [7:0] addr;
        logic [7:0] wd;
        for (int n = 0; n < 300; n++) begin
            mem_lat = $urandom_range(1, 3);
            wr   = $urandom_range(0, 1);
            both = wr && ($urandom_range(0, 3) == 0);
            addr = 8'($urandom);
            wd   = 8'($urandom);
            do_access(wr, both, addr, wd);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_store[i] = $urandom;
            ref_mem[i]   = mem_store[i];
        end
        mem_store[1] = 32'h4433_2211;
        ref_mem[1]   = 32'h4433_2211;
        model_clear();
        repeat (2) @(posedge CLK);
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_dirty_evict();
        test_write_miss();
        test_reset_mid_miss();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
